// File: rtl/mha_stat_pkg.sv
// Shared definitions for the mi/li statistics path of the MHA flash-attention datapath.
// Holds the default vector geometry, the RMW controller state encoding and the lane-vector type.
package mha_stat_pkg;

  localparam int D_W    = 16;
  localparam int SA_R   = 16;
  localparam int ADDR_W = 6;

  // Most negative fixed-point value: the max identity, used before any tile has been seen
  localparam logic [D_W-1:0] MI_NEG_INF = {1'b1, {(D_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CORR,
    WR_REQ,
    WR_WAIT
  } state_t;

  typedef logic signed [SA_R-1:0][D_W-1:0] vec_t;

endpackage

// File: rtl/vec_smax.sv
// Combinational per-lane signed maximum of two lane vectors.
// Shared between the mi/li RMW controller and the softmax tile engine.
module vec_smax #(
  parameter int D_W  = 16,
  parameter int SA_R = 16
) (
  input  logic [SA_R-1:0][D_W-1:0] a,
  input  logic [SA_R-1:0][D_W-1:0] b,
  output logic [SA_R-1:0][D_W-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < SA_R; i++) begin
      y[i] = ($signed(a[i]) > $signed(b[i])) ? a[i] : b[i];
    end
  end

endmodule

// File: rtl/mi_li_rmw_ctrl.sv
// Read-modify-write controller for the mi/li statistics BRAM: merges a tile's row max into the
// stored running max, hands old/new mi to the exp unit and writes back mi and the rescaled li.
module mi_li_rmw_ctrl #(
  parameter int                    D_W        = mha_stat_pkg::D_W,
  parameter int                    SA_R       = mha_stat_pkg::SA_R,
  parameter int                    ADDR_W     = mha_stat_pkg::ADDR_W,
  parameter logic [D_W-1:0]        MI_NEG_INF = {1'b1, {(D_W-1){1'b0}}}
) (
  input  logic                      I_CLK,
  input  logic                      I_RST_N,
  input  logic                      I_START,
  input  logic                      I_FIRST,
  input  logic [ADDR_W-1:0]         I_ADDR,
  input  logic [SA_R-1:0][D_W-1:0]  I_TILE_MAX_VEC,
  output logic                      O_READY,
  output logic                      O_RD_ENA,
  output logic                      O_WR_ENA,
  output logic [ADDR_W-1:0]         O_ADDR,
  output logic [SA_R-1:0][D_W-1:0]  O_WR_MI_VEC,
  output logic [SA_R-1:0][D_W-1:0]  O_WR_LI_VEC,
  input  logic                      I_MGR_BUSY,
  input  logic                      I_MGR_VLD,
  input  logic [SA_R-1:0][D_W-1:0]  I_RD_MI_VEC,
  input  logic [SA_R-1:0][D_W-1:0]  I_RD_LI_VEC,
  output logic                      O_CORR_VLD,
  output logic [SA_R-1:0][D_W-1:0]  O_MI_OLD_VEC,
  output logic [SA_R-1:0][D_W-1:0]  O_MI_NEW_VEC,
  output logic [SA_R-1:0][D_W-1:0]  O_LI_OLD_VEC,
  input  logic                      I_LI_VLD,
  input  logic [SA_R-1:0][D_W-1:0]  I_LI_NEW_VEC,
  output logic                      O_DONE
);

  import mha_stat_pkg::*;

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDR_W-1:0]        addr_q;
  logic [SA_R-1:0][D_W-1:0] tile_q;
  logic [SA_R-1:0][D_W-1:0] mi_old_q;
  logic [SA_R-1:0][D_W-1:0] li_old_q;
  logic [SA_R-1:0][D_W-1:0] mi_new_q;
  logic [SA_R-1:0][D_W-1:0] li_new_q;
  logic [SA_R-1:0][D_W-1:0] smax_a;
  logic [SA_R-1:0][D_W-1:0] smax_b;
  logic [SA_R-1:0][D_W-1:0] smax_y;
  logic [SA_R-1:0][D_W-1:0] neg_inf_vec;

  assign neg_inf_vec = {SA_R{MI_NEG_INF}};

  // One max unit serves both CORR entry paths, so mi_new is registered on the entering edge
  vec_smax #(.D_W(D_W), .SA_R(SA_R)) u_smax (
    .a (smax_a),
    .b (smax_b),
    .y (smax_y)
  );

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    smax_a     = neg_inf_vec;
    smax_b     = I_TILE_MAX_VEC;
    O_READY    = 1'b0;
    O_RD_ENA   = 1'b0;
    O_WR_ENA   = 1'b0;
    O_CORR_VLD = 1'b0;
    O_DONE     = 1'b0;
    case (state)
      IDLE: begin
        O_READY = 1'b1;
        if (I_START) state_nxt = I_FIRST ? CORR : RD_REQ;
      end
      RD_REQ: begin
        if (!I_MGR_BUSY) begin
          O_RD_ENA  = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        smax_a = I_RD_MI_VEC;
        smax_b = tile_q;
        if (I_MGR_VLD) state_nxt = CORR;
      end
      CORR: begin
        O_CORR_VLD = 1'b1;
        if (I_LI_VLD) state_nxt = WR_REQ;
      end
      WR_REQ: begin
        if (!I_MGR_BUSY) begin
          O_WR_ENA  = 1'b1;
          state_nxt = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (!I_MGR_BUSY) begin
          O_DONE    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      addr_q   <= '0;
      tile_q   <= '0;
      mi_old_q <= '0;
      li_old_q <= '0;
      mi_new_q <= '0;
      li_new_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (I_START) begin
            addr_q <= I_ADDR;
            tile_q <= I_TILE_MAX_VEC;
            if (I_FIRST) begin
              mi_old_q <= neg_inf_vec;
              li_old_q <= '0;
              mi_new_q <= smax_y;
            end
          end
        end
        RD_WAIT: begin
          if (I_MGR_VLD) begin
            mi_old_q <= I_RD_MI_VEC;
            li_old_q <= I_RD_LI_VEC;
            mi_new_q <= smax_y;
          end
        end
        CORR: begin
          if (I_LI_VLD) li_new_q <= I_LI_NEW_VEC;
        end
        default: ;
      endcase
    end
  end

  assign O_ADDR       = addr_q;
  assign O_MI_OLD_VEC = mi_old_q;
  assign O_MI_NEW_VEC = mi_new_q;
  assign O_LI_OLD_VEC = li_old_q;
  assign O_WR_MI_VEC  = mi_new_q;
  assign O_WR_LI_VEC  = li_new_q;

endmodule
